// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/execute sequencer for the single-cycle
// RISC-V datapath. Owns the PC, fetches over a req/rvalid handshake, holds
// each word on inst and pulses exec_en once per executed instruction.
// Supports continuous run, halt and single-step for bring-up and debug.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   run, step         - run level / single-step pulse (honoured in HALT only)
//   imem_req/addr     - fetch request and address (addr == pc)
//   imem_rvalid/rdata - fetch response
//   inst, exec_en, pc - instruction, commit pulse and its address
//   retired, halted   - executed-instruction count, HALT state flag
//   illegal           - sticky illegal-opcode flag
//
// Optional feature macro: ILLEGAL_TRAP_EN (opcode check with halt-on-illegal).
// Without it every fetched word executes and illegal stays 0.

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        exec_en,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   step_flag, step_flag_nxt;
    logic   illegal_q;
    logic   fetch_done;
    logic   retire;
    logic   bad_op;

`ifdef ILLEGAL_TRAP_EN
    // Only R-type, I-type ALU and store opcodes are supported.
    always_comb begin
        bad_op = 1'b1;
        unique case (imem_rdata[6:0])
            7'b0110011: bad_op = 1'b0;
            7'b0010011: bad_op = 1'b0;
            7'b0100011: bad_op = 1'b0;
            default:    bad_op = 1'b1;
        endcase
    end
`else
    assign bad_op = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        step_flag_nxt = step_flag;
        fetch_done    = 1'b0;
        retire        = 1'b0;
        unique case (state)
            HALT: begin
                // A trapped sequencer stays parked until reset.
                if (!illegal_q) begin
                    if (run) begin
                        state_nxt = FETCH;
                    end else if (step) begin
                        state_nxt     = FETCH;
                        step_flag_nxt = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (imem_rvalid) begin
                    fetch_done = 1'b1;
                    state_nxt  = bad_op ? HALT : EXEC;
                end
            end
            EXEC: begin
                retire        = 1'b1;
                step_flag_nxt = 1'b0;
                state_nxt     = (run && !step_flag) ? FETCH : HALT;
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HALT;
            step_flag <= 1'b0;
            illegal_q <= 1'b0;
            pc        <= RESET_PC;
            inst      <= NOP_INST;
            retired   <= 32'd0;
        end else begin
            state     <= state_nxt;
            step_flag <= step_flag_nxt;
            if (fetch_done) begin
                inst <= imem_rdata;
            end
            if (fetch_done && bad_op) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                pc      <= pc + 32'd4;
                retired <= retired + 32'd1;
            end
        end
    end

    // Outputs decode registered state only.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign exec_en   = (state == EXEC);
    assign halted    = (state == HALT);
    assign illegal   = illegal_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction sequencer that drives the single-cycle RISC-V datapath. It owns the program counter, fetches 32-bit words from instruction memory over a request/valid handshake, and holds each word stable on `inst`. It qualifies each execution with a one-cycle `exec_en` pulse that gates register-file writes, and provides run/halt/single-step control for bring-up and debug.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.
- `NOP_INST`, default `32'h0000_0013` (`addi x0,x0,0`): `inst` value after reset.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: level; high means fetch/execute continuously.
- `step` in 1: one-cycle pulse; executes exactly one instruction when halted.
- `imem_req` out 1: fetch request; held high until `imem_rvalid`.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_rvalid` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `inst` out 32: registered instruction driven to the datapath.
- `exec_en` out 1: one-cycle pulse; datapath commits `inst` (ANDed into `reg_write`).
- `pc` out 32: address of `inst`.
- `retired` out 32: count of executed instructions.
- `halted` out 1: sequencer in HALT.
- `illegal` out 1: sticky illegal-opcode flag (see Configuration).

## Operation

- States: HALT (reset state), FETCH, EXEC.
- HALT -> FETCH when `run`=1, or when `step`=1 with a single-step flag set. `run` has priority if both are high. `step` is ignored outside HALT.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_rvalid`=1, register `inst`<=`imem_rdata` and go to EXEC.
  - Without `imem_rvalid`, remain in FETCH indefinitely.
- EXEC: `exec_en`=1 for exactly this cycle.
  - On the exiting edge: `pc`<=`pc`+4 (mod 2^32; `32'hFFFF_FFFC` wraps to 0) and `retired`<=`retired`+1 (mod 2^32).
  - Next state: FETCH if `run`=1 and the single-step flag is clear; otherwise HALT. The single-step flag clears here.
- Deasserting `run` during FETCH does not abandon the outstanding request: the fetch completes and executes, then the sequencer goes to HALT.
- `imem_rvalid` outside FETCH is ignored.
- `inst` holds its value in HALT. `pc` always names the next word to fetch except during EXEC, when it names `inst`.
- `halted` = (state == HALT).

## Timing

- Reset values: `pc`=`RESET_PC`, `inst`=`NOP_INST`, `imem_req`=0, `exec_en`=0, `retired`=0, `halted`=1, `illegal`=0, state HALT, single-step flag 0.
- `rst` in any state (including mid-fetch) takes effect on the next edge. `imem_req` is low in the following cycle, and the pending response is dropped.
- Minimum throughput is 2 cycles per instruction, with a zero-wait memory (`imem_rvalid` in the same cycle as `imem_req`).
- Each memory wait cycle adds one cycle.
- `exec_en` asserts the cycle after the `imem_rvalid` sample edge.
- `run` rising in HALT: `imem_req` is high the next cycle.
- All outputs are registered, or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration

- `ILLEGAL_TRAP_EN` defined:
  - In FETCH with `imem_rvalid`=1, the opcode `imem_rdata[6:0]` is checked against R-type `7'b0110011`, I-type `7'b0010011`, and store `7'b0100011`.
  - Any other opcode: latch `inst`, go to HALT without `exec_en`, leave `pc` and `retired` unchanged, and set `illegal`=1.
  - `illegal` is sticky until `rst`. While set, `run` and `step` are ignored.
- `ILLEGAL_TRAP_EN` undefined: every fetched word executes, and `illegal` is tied to 0.

## Test plan

- Reset, `run`=1, zero-wait memory returning `32'h0020_81B3` (`add x3,x1,x2`) -> `exec_en` pulses every 2nd cycle; `imem_addr` sequence 0,4,8; `retired`=3 after the third pulse.
- Memory with 3 wait cycles -> `imem_req` is held for 4 cycles at a stable address; one `exec_en` per 5 cycles.
- Halted, one `step` pulse -> exactly one fetch and one `exec_en`; `pc` 0->4, `retired` 0->1, back to HALT. A second `step` during FETCH is ignored.
- `run` dropped in the cycle after `imem_req` rises, `imem_rvalid` two cycles later -> the instruction still executes once, then `halted`=1.
- `RESET_PC`=`32'hFFFF_FFFC`, run one instruction -> `pc` wraps to `32'h0000_0000`.
- `ILLEGAL_TRAP_EN` defined, fetch `32'h0000_0003` (load) -> `halted`=1, `illegal`=1, `exec_en` never asserted, `pc` unchanged; `run` is ignored until `rst`.
